// File: rtl/vector_pkg.sv
// Shared types and helpers for the vector display line path.
// Holds the line FSM encoding, default widths and the frame test.
package vector_pkg;

    localparam int OUT_WIDTH_DEF  = 8;
    localparam int BRES_WIDTH_DEF = OUT_WIDTH_DEF + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } line_state_t;

    // Point lies inside 0..2^ow-1 on both axes.
    function automatic logic in_frame(
        input logic signed [31:0] x,
        input logic signed [31:0] y,
        input int                 ow
    );
        logic signed [31:0] top;
        top = (32'sd1 <<< ow) - 32'sd1;
        return (x >= 0) && (y >= 0) && (x <= top) && (y <= top);
    endfunction

endpackage

// File: rtl/vector_line_setup.sv
// Combinational Bresenham setup: deltas, step directions, initial error.
// The parent registers these outputs while in SETUP.
module vector_line_setup
    import vector_pkg::*;
#(
    parameter int BRES_WIDTH = BRES_WIDTH_DEF
) (
    input  logic signed [BRES_WIDTH-1:0] sta_x,
    input  logic signed [BRES_WIDTH-1:0] sta_y,
    input  logic signed [BRES_WIDTH-1:0] end_x,
    input  logic signed [BRES_WIDTH-1:0] end_y,
    output logic signed [BRES_WIDTH+1:0] dx,
    output logic signed [BRES_WIDTH+1:0] dy,
    output logic signed [BRES_WIDTH+1:0] err,
    output logic                         sx_neg,
    output logic                         sy_neg
);

    localparam int EW = BRES_WIDTH + 2;

    logic signed [EW-1:0] diff_x;
    logic signed [EW-1:0] diff_y;

    always_comb begin
        diff_x = {{2{end_x[BRES_WIDTH-1]}}, end_x}
               - {{2{sta_x[BRES_WIDTH-1]}}, sta_x};
        diff_y = {{2{end_y[BRES_WIDTH-1]}}, end_y}
               - {{2{sta_y[BRES_WIDTH-1]}}, sta_y};
        sx_neg = diff_x[EW-1];
        sy_neg = diff_y[EW-1];
        dx     = sx_neg ? -diff_x : diff_x;
        // dy is kept as the negated magnitude
        dy     = sy_neg ? diff_y : -diff_y;
        err    = dx + dy;
    end

endmodule

// File: rtl/vector_line_draw.sv
// All-octant Bresenham line rasteriser with a valid/ready pixel stream.
// Out-of-frame points are walked silently, one per cycle.
module vector_line_draw
    import vector_pkg::*;
#(
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
    parameter int BRES_WIDTH = OUT_WIDTH + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         go,
    input  logic signed [BRES_WIDTH-1:0] stax,
    input  logic signed [BRES_WIDTH-1:0] stay,
    input  logic signed [BRES_WIDTH-1:0] endx,
    input  logic signed [BRES_WIDTH-1:0] endy,
    output logic                         busy,
    output logic                         done,
    output logic                         plot,
    output logic [OUT_WIDTH-1:0]         x_out,
    output logic [OUT_WIDTH-1:0]         y_out,
    input  logic                         ready
);

    localparam int EW = BRES_WIDTH + 2;

    line_state_t state_q, state_d;

    logic signed [BRES_WIDTH-1:0] cur_x_q, cur_x_d;
    logic signed [BRES_WIDTH-1:0] cur_y_q, cur_y_d;
    logic signed [BRES_WIDTH-1:0] end_x_q, end_x_d;
    logic signed [BRES_WIDTH-1:0] end_y_q, end_y_d;
    logic signed [EW-1:0]         dx_q, dx_d;
    logic signed [EW-1:0]         dy_q, dy_d;
    logic signed [EW-1:0]         err_q, err_d;
    logic                         sx_neg_q, sx_neg_d;
    logic                         sy_neg_q, sy_neg_d;

    logic signed [EW-1:0] su_dx, su_dy, su_err;
    logic                 su_sx_neg, su_sy_neg;

    logic signed [EW:0] e2, dx_e, dy_e;
    logic               in_fr;
    logic               retire;
    logic               at_end;
    logic               step_x;
    logic               step_y;

    // Start point already sits in cur_* when SETUP runs.
    vector_line_setup #(
        .BRES_WIDTH(BRES_WIDTH)
    ) u_setup (
        .sta_x  (cur_x_q),
        .sta_y  (cur_y_q),
        .end_x  (end_x_q),
        .end_y  (end_y_q),
        .dx     (su_dx),
        .dy     (su_dy),
        .err    (su_err),
        .sx_neg (su_sx_neg),
        .sy_neg (su_sy_neg)
    );

    always_comb begin
        state_d  = state_q;
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;
        end_x_d  = end_x_q;
        end_y_d  = end_y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        err_d    = err_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;

        in_fr  = in_frame(32'(cur_x_q), 32'(cur_y_q), OUT_WIDTH);
        retire = in_fr ? ready : 1'b1;
        at_end = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);
        e2     = {err_q, 1'b0};
        dx_e   = {dx_q[EW-1], dx_q};
        dy_e   = {dy_q[EW-1], dy_q};
        step_x = (e2 >= dy_e);
        step_y = (e2 <= dx_e);

        unique case (state_q)
            IDLE: begin
                if (go) begin
                    cur_x_d = stax;
                    cur_y_d = stay;
                    end_x_d = endx;
                    end_y_d = endy;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                dx_d     = su_dx;
                dy_d     = su_dy;
                err_d    = su_err;
                sx_neg_d = su_sx_neg;
                sy_neg_d = su_sy_neg;
                state_d  = DRAW;
            end
            DRAW: begin
                if (retire) begin
                    if (at_end) begin
                        state_d = DONE;
                    end else begin
                        // Both axis updates see the pre-update error.
                        if (step_x) begin
                            err_d   = err_d + dy_q;
                            cur_x_d = sx_neg_q
                                ? cur_x_q - BRES_WIDTH'(1)
                                : cur_x_q + BRES_WIDTH'(1);
                        end
                        if (step_y) begin
                            err_d   = err_d + dx_q;
                            cur_y_d = sy_neg_q
                                ? cur_y_q - BRES_WIDTH'(1)
                                : cur_y_q + BRES_WIDTH'(1);
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            end_x_q  <= '0;
            end_y_q  <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            end_x_q  <= end_x_d;
            end_y_q  <= end_y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            err_q    <= err_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
        end
    end

    assign busy  = (state_q == SETUP) || (state_q == DRAW);
    assign done  = (state_q == DONE);
    assign plot  = (state_q == DRAW) && in_fr;
    assign x_out = cur_x_q[OUT_WIDTH-1:0];
    assign y_out = cur_y_q[OUT_WIDTH-1:0];

endmodule

// File: tb/tb_vector_line_draw.sv
// Scoreboard bench for vector_line_draw: directed segments with
// hand-computed pixels, cycles and done timing.
module tb_vector_line_draw;

    localparam int OW = 8;
    localparam int BW = 9;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 go;
    logic                 ready;
    logic signed [BW-1:0] stax, stay, endx, endy;
    logic                 busy, done, plot;
    logic [OW-1:0]        x_out, y_out;

    vector_line_draw #(
        .OUT_WIDTH  (OW),
        .BRES_WIDTH (BW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .go    (go),
        .stax  (stax),
        .stay  (stay),
        .endx  (endx),
        .endy  (endy),
        .busy  (busy),
        .done  (done),
        .plot  (plot),
        .x_out (x_out),
        .y_out (y_out),
        .ready (ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int comps = 0;
    int fails = 0;

    typedef struct {
        int x;
        int y;
        int c;
    } px_t;

    px_t pxq[$];
    int  doneq[$];

    task automatic check(input string name, input int act, input int exp);
        comps++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push_px(input int x, input int y, input int c);
        px_t p;
        p.x = x;
        p.y = y;
        p.c = c;
        pxq.push_back(p);
    endtask

    // Monitor: pops the scoreboard on every accepted pixel / done pulse.
    bit  hold_v = 1'b0;
    int  hold_x, hold_y;
    px_t mp;

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_plot", int'(plot), 1);
                check("hold_x", int'(x_out), hold_x);
                check("hold_y", int'(y_out), hold_y);
            end
            hold_v = 1'b0;
            if (plot) begin
                if (ready) begin
                    if (pxq.size() == 0) begin
                        check("unexpected_plot", int'(plot), 0);
                    end else begin
                        mp = pxq.pop_front();
                        check("px_x", int'(x_out), mp.x);
                        check("px_y", int'(y_out), mp.y);
                        if (mp.c >= 0) check("px_cycle", cyc, mp.c);
                    end
                end else begin
                    hold_v = 1'b1;
                    hold_x = int'(x_out);
                    hold_y = int'(y_out);
                end
            end
            if (done) begin
                check("busy_at_done", int'(busy), 0);
                if (doneq.size() == 0)
                    check("unexpected_done", int'(done), 0);
                else
                    check("done_cycle", cyc, doneq.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic start_seg(input int x0, input int y0,
                             input int x1, input int y1,
                             output int t);
        go   = 1'b1;
        stax = BW'(x0);
        stay = BW'(y0);
        endx = BW'(x1);
        endy = BW'(y1);
        t    = cyc;
        step();
        go   = 1'b0;
        check("busy_setup", int'(busy), 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((pxq.size() > 0 || doneq.size() > 0 || busy || done)
               && n < 200) begin
            step();
            n++;
        end
        check("drain", pxq.size() + doneq.size(), 0);
        check("idle_busy", int'(busy), 0);
    endtask

    initial begin
        int t;
        rst   = 1'b1;
        go    = 1'b0;
        ready = 1'b1;
        stax  = '0;
        stay  = '0;
        endx  = '0;
        endy  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_plot", int'(plot), 0);
        check("rst_x", int'(x_out), 0);
        check("rst_y", int'(y_out), 0);
        rst = 1'b0;
        step();

        // Horizontal
        start_seg(10, 20, 14, 20, t);
        for (int i = 0; i < 5; i++) push_px(10 + i, 20, t + 2 + i);
        doneq.push_back(t + 7);
        wait_until(t + 6);
        check("horiz_busy_last", int'(busy), 1);
        check("horiz_done_early", int'(done), 0);
        drain();

        // Steep
        start_seg(0, 0, 2, 5, t);
        push_px(0, 0, t + 2);
        push_px(0, 1, -1);
        push_px(1, 2, -1);
        push_px(1, 3, -1);
        push_px(2, 4, -1);
        push_px(2, 5, t + 7);
        doneq.push_back(t + 8);
        drain();

        // Reverse diagonal
        start_seg(5, 5, 2, 2, t);
        for (int i = 0; i < 4; i++) push_px(5 - i, 5 - i, t + 2 + i);
        doneq.push_back(t + 6);
        drain();

        // Zero length
        start_seg(7, 7, 7, 7, t);
        push_px(7, 7, t + 2);
        doneq.push_back(t + 3);
        drain();

        // Backpressure
        start_seg(10, 20, 14, 20, t);
        push_px(10, 20, t + 2);
        push_px(11, 20, t + 6);
        push_px(12, 20, t + 7);
        push_px(13, 20, t + 8);
        push_px(14, 20, t + 9);
        doneq.push_back(t + 10);
        wait_until(t + 3);
        ready = 1'b0;
        wait_until(t + 6);
        ready = 1'b1;
        drain();

        // Clip
        start_seg(-2, 0, 1, 0, t);
        push_px(0, 0, t + 4);
        push_px(1, 0, t + 5);
        doneq.push_back(t + 6);
        wait_until(t + 2);
        check("clip_plot_t2", int'(plot), 0);
        wait_until(t + 3);
        check("clip_plot_t3", int'(plot), 0);
        drain();

        // Abort
        start_seg(10, 20, 14, 20, t);
        push_px(10, 20, t + 2);
        push_px(11, 20, t + 3);
        wait_until(t + 4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_plot", int'(plot), 0);
        check("abort_x", int'(x_out), 0);
        check("abort_y", int'(y_out), 0);
        repeat (5) step();
        drain();

        // Ignored restart
        start_seg(0, 0, 4, 0, t);
        for (int i = 0; i < 5; i++) push_px(i, 0, t + 2 + i);
        doneq.push_back(t + 7);
        wait_until(t + 3);
        go   = 1'b1;
        stax = BW'(100);
        stay = BW'(100);
        endx = BW'(50);
        endy = BW'(60);
        step();
        go = 1'b0;
        drain();
        repeat (4) step();
        check("restart_idle_plot", int'(plot), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 comps, fails);
        $finish;
    end

endmodule
